fifo_prog: RTL and testbench

FIFO_PROG -- requirements
Module: fifo_prog

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 40 ++++
 rtl/fifo_prog.sv | 138 +++++++++++++
 tb/tb_fifo_prog.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable FIFO slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count
//   count_width()                 : bits needed to hold an occupancy 0..depth
//   ptr_width()                   : bits needed to address depth entries
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Occupancy runs from 0 to depth inclusive, hence depth+1 states.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A depth of 1 would give $clog2 == 0; keep at least one address bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Storage array for fifo_prog: synchronous write, asynchronous read.
// The array is deliberately not reset.
// Ports:
//   clk      : write clock, rising edge
//   wr_en    : write strobe (already qualified by the FIFO control)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data at rd_addr
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ptr_width(DEFAULT_DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Plain register-array write; contents survive reset on purpose so the
    // array can map onto storage without a reset network.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// ---------------------------------------------------------------------------
// fifo_prog
// Synchronous FIFO with programmable depth (any value, not only powers of
// two), programmable almost-full / almost-empty levels and 1-cycle pulse
// handshake flags.
// Optional build macro: FIFO_FWFT_EN -- data_out shows the head entry
// combinationally (first-word fall-through) instead of a registered read.
// Ports:
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   data_in       : write data
//   wr_en, rd_en  : write / read requests
//   data_out      : read data
//   wr_ack        : pulse, write accepted last cycle
//   overflow      : pulse, write rejected (full) last cycle
//   underflow     : pulse, read rejected (empty) last cycle
//   full, empty, almostfull, almostempty : decoded from count
//   count         : current occupancy
// ---------------------------------------------------------------------------
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_DEPTH,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [FIFO_WIDTH-1:0]               data_in,
    input  logic                                wr_en,
    input  logic                                rd_en,
    output logic [FIFO_WIDTH-1:0]               data_out,
    output logic                                wr_ack,
    output logic                                overflow,
    output logic                                underflow,
    output logic                                full,
    output logic                                empty,
    output logic                                almostfull,
    output logic                                almostempty,
    output logic [count_width(FIFO_DEPTH)-1:0]  count
);

    localparam int CW = count_width(FIFO_DEPTH);
    localparam int PW = ptr_width(FIFO_DEPTH);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [CW-1:0]         count_next;
    logic [FIFO_WIDTH-1:0] head_data;

    // Pointers wrap by explicit compare so odd depths never alias.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign almostfull  = (count == AF_CNT);
    assign almostempty = (count == AE_CNT);

    // Acceptance is judged on the current occupancy, so a simultaneous
    // request at an empty FIFO keeps only the write, and at a full FIFO
    // keeps only the read.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    // Occupancy changes only when exactly one side is accepted.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and the handshake pulses. Each pulse is rewritten
    // every cycle, so it drops back to 0 unless its event recurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            wr_ack    <= wr_ok;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_ok) begin
                wr_ptr <= advance(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= advance(rd_ptr);
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Fall-through: the head entry is visible whenever data is held; a read
    // just moves rd_ptr on. Shows zero while empty so stale array contents
    // never leak out after reset.
    assign data_out = empty ? '0 : head_data;
`else
    // Registered read: the head entry is captured on an accepted read and
    // held otherwise, including across rejected reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= head_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_fifo_prog
// Self-checking bench for fifo_prog. Two instances run side by side:
//   index 0 : WIDTH 16, DEPTH 8, AF_LEVEL 6, AE_LEVEL 2
//   index 1 : WIDTH 16, DEPTH 5, default levels (AF 4, AE 1)
// A queue-based reference model predicts every output after each clock.
// ---------------------------------------------------------------------------
module tb_fifo_prog;

    logic clk = 1'b0;

    logic        rst8 = 1'b0, wr8 = 1'b0, rd8 = 1'b0;
    logic [15:0] din8 = '0;
    logic [15:0] dout8;
    logic        ack8, ovf8, unf8, full8, empty8, af8, ae8;
    logic [3:0]  cnt8;

    logic        rst5 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;
    logic [15:0] din5 = '0;
    logic [15:0] dout5;
    logic        ack5, ovf5, unf5, full5, empty5, af5, ae5;
    logic [2:0]  cnt5;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, one slot per instance.
    logic [15:0] q [2][$];
    logic [15:0] exp_dout [2];
    logic        exp_ack  [2];
    logic        exp_ovf  [2];
    logic        exp_unf  [2];
    int          depth_of [2] = '{8, 5};
    int          af_of    [2] = '{6, 4};
    int          ae_of    [2] = '{2, 1};

    fifo_prog #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut8 (
        .clk         (clk),
        .rst         (rst8),
        .data_in     (din8),
        .wr_en       (wr8),
        .rd_en       (rd8),
        .data_out    (dout8),
        .wr_ack      (ack8),
        .overflow    (ovf8),
        .underflow   (unf8),
        .full        (full8),
        .empty       (empty8),
        .almostfull  (af8),
        .almostempty (ae8),
        .count       (cnt8)
    );

    fifo_prog #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (5)
    ) dut5 (
        .clk         (clk),
        .rst         (rst5),
        .data_in     (din5),
        .wr_en       (wr5),
        .rd_en       (rd5),
        .data_out    (dout5),
        .wr_ack      (ack5),
        .overflow    (ovf5),
        .underflow   (unf5),
        .full        (full5),
        .empty       (empty5),
        .almostfull  (af5),
        .almostempty (ae5),
        .count       (cnt5)
    );

    // Free-running 10-unit clock shared by both instances.
    always #5 clk = ~clk;

    // Single comparison point: counts it, and on a miss counts the failure
    // and reports tag, observed and expected values.
    task automatic compareField(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Compares every output of the selected instance with the model.
    task automatic checkOutput(input int sel);
        logic [31:0] o_cnt, o_dout;
        logic        o_full, o_empty, o_af, o_ae, o_ack, o_ovf, o_unf;
        int          n;
        string       p;
        if (sel == 0) begin
            o_cnt = 32'(cnt8);  o_dout = 32'(dout8);
            o_full = full8; o_empty = empty8; o_af = af8; o_ae = ae8;
            o_ack = ack8; o_ovf = ovf8; o_unf = unf8;
        end else begin
            o_cnt = 32'(cnt5);  o_dout = 32'(dout5);
            o_full = full5; o_empty = empty5; o_af = af5; o_ae = ae5;
            o_ack = ack5; o_ovf = ovf5; o_unf = unf5;
        end
        n = q[sel].size();
        p = (sel == 0) ? "d8" : "d5";
        compareField({p, "_count"},       o_cnt,          32'(n));
        compareField({p, "_full"},        32'(o_full),    32'(n == depth_of[sel]));
        compareField({p, "_empty"},       32'(o_empty),   32'(n == 0));
        compareField({p, "_almostfull"},  32'(o_af),      32'(n == af_of[sel]));
        compareField({p, "_almostempty"}, 32'(o_ae),      32'(n == ae_of[sel]));
        compareField({p, "_wr_ack"},      32'(o_ack),     32'(exp_ack[sel]));
        compareField({p, "_overflow"},    32'(o_ovf),     32'(exp_ovf[sel]));
        compareField({p, "_underflow"},   32'(o_unf),     32'(exp_unf[sel]));
        compareField({p, "_data_out"},    o_dout,         32'(exp_dout[sel]));
    endtask

    // One clock of stimulus on the selected instance (the other idles),
    // followed by the model update and a full output check.
    task automatic applyStimulus(input int sel, input logic wr, input logic rd,
                                 input logic [15:0] din, input logic rs);
        int          n;
        logic [15:0] popped;
        @(negedge clk);
        rst8 = 1'b0; wr8 = 1'b0; rd8 = 1'b0;
        rst5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;
        if (sel == 0) begin
            rst8 = rs; wr8 = wr; rd8 = rd; din8 = din;
        end else begin
            rst5 = rs; wr5 = wr; rd5 = rd; din5 = din;
        end
        @(posedge clk);
        #1;
        if (rs) begin
            q[sel].delete();
            exp_dout[sel] = '0;
            exp_ack[sel]  = 1'b0;
            exp_ovf[sel]  = 1'b0;
            exp_unf[sel]  = 1'b0;
        end else begin
            n = q[sel].size();
            exp_ack[sel] = wr && (n < depth_of[sel]);
            exp_ovf[sel] = wr && (n == depth_of[sel]);
            exp_unf[sel] = rd && (n == 0);
            if (rd && n > 0) begin
                popped = q[sel].pop_front();
                exp_dout[sel] = popped;
            end
            if (wr && n < depth_of[sel]) begin
                q[sel].push_back(din);
            end
        end
`ifdef FIFO_FWFT_EN
        exp_dout[sel] = (q[sel].size() > 0) ? q[sel][0] : '0;
`endif
        checkOutput(sel);
    endtask

    initial begin
        $display("[TB] starting fifo_prog bench");

        // Reset both instances and check the cleared state.
        applyStimulus(0, 1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Fill to full, then one write too many.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 16'(i), 1'b0);
        end

        // Drain in order, then one read too many (data_out holds).
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 16'h0000, 1'b0);
        end

        // Simultaneous read+write at empty, full and mid occupancy.
        applyStimulus(0, 1'b1, 1'b1, 16'h00A0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 16'h00A0 + 16'(i), 1'b0);
        end
        applyStimulus(0, 1'b1, 1'b1, 16'h00B0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'h00B1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 16'h0000, 1'b0);
        end
        applyStimulus(0, 1'b1, 1'b1, 16'h00C0, 1'b0);

        // Reset while holding five entries; requests are ignored that cycle.
        applyStimulus(0, 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 16'h0D00 + 16'(i), 1'b0);
        end
        applyStimulus(0, 1'b1, 1'b1, 16'hDEAD, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 16'h0000, 1'b0);

        // Depth-5 instance: interleaved traffic that wraps both pointers.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(1, (i % 4) != 3, (i >= 2) && ((i % 4) != 0),
                          16'h5000 + 16'(i), 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1'b0, 1'b1, 16'h0000, 1'b0);
        end

        // Random traffic on both instances with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(int'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          16'($urandom),
                          $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
